// File: rtl/viterbi_channel_injector.sv
// Registered channel model between encoder and Viterbi decoder: XORs a mask into selected symbols.
// Define VITERBI_INJ_LFSR_EN to build the LFSR-driven RANDOM mode; otherwise mode 3 behaves as OFF.
module viterbi_channel_injector #(
  parameter int unsigned SYM_W     = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BURST_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load_i,
  input  logic [1:0]         mode_i,
  input  logic [CNT_W-1:0]   start_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [SYM_W-1:0]   mask_i,
  input  logic [15:0]        thresh_i,
  input  logic               valid_i,
  input  logic [SYM_W-1:0]   sym_i,
  output logic               valid_o,
  output logic [SYM_W-1:0]   sym_o,
  output logic               err_o,
  output logic               active_o,
  output logic [CNT_W-1:0]   sym_ct_o,
  output logic [CNT_W-1:0]   bad_bit_ct_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
  typedef enum logic [1:0] {M_OFF, M_ONESHOT, M_PERIODIC, M_RANDOM} mode_t;

`ifdef VITERBI_INJ_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  state_t             r_state;
  mode_t              r_mode;
  logic [CNT_W-1:0]   r_start, r_period, r_pcnt, r_sym_ct, r_bad_ct;
  logic [BURST_W-1:0] r_burst_len, r_bcnt;
  logic [SYM_W-1:0]   r_mask, r_sym;
  logic               r_cont, r_first, r_idx_sat;
  logic               r_valid, r_err, r_active;

  logic               w_rnd_hit, w_match, w_hit, w_burst_end;
  logic [CNT_W-1:0]   w_pop;
  logic [CNT_W:0]     w_bad_sum;
  logic [BURST_W-1:0] w_bcnt_nxt;
  state_t             w_load_state, w_state_nxt;

`ifdef VITERBI_INJ_LFSR_EN
  logic [15:0] r_thresh, r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_thresh <= '0;
      r_lfsr   <= LFSR_SEED;
    end else if (cfg_load_i) begin
      r_thresh <= thresh_i;
      r_lfsr   <= LFSR_SEED;
    end else if (valid_i) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_rnd_hit = (r_mode == M_RANDOM) && (r_state == S_WAIT) &&
                     (r_sym_ct >= r_start) && (r_lfsr < r_thresh);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{thresh_i, LFSR_SEED};
  assign w_rnd_hit    = 1'b0;
`endif

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < SYM_W; i++) w_pop = w_pop + CNT_W'(r_mask[i]);
    w_bad_sum = {1'b0, r_bad_ct} + {1'b0, w_pop};
    // the symbol index doubles as the valid-symbol counter; the first PERIODIC burst keys on it
    w_match = (r_mode == M_PERIODIC && !r_first) ? (r_pcnt == r_period)
                                                  : (r_sym_ct == r_start && !r_idx_sat);
    w_hit = valid_i && !cfg_load_i &&
            (((r_state == S_WAIT) && (r_mode != M_RANDOM) && w_match) ||
             (r_state == S_BURST) || w_rnd_hit);
    w_bcnt_nxt  = (r_state == S_BURST) ? r_bcnt + BURST_W'(1) : BURST_W'(1);
    w_burst_end = (w_bcnt_nxt == r_burst_len) && !r_cont;

    case (mode_i)
      M_OFF:    w_load_state = S_IDLE;
      M_RANDOM: w_load_state = LFSR_EN ? S_WAIT : S_IDLE;
      default:  w_load_state = (burst_len_i == '0) ? S_DONE : S_WAIT;
    endcase

    w_state_nxt = r_state;
    if (cfg_load_i)
      w_state_nxt = w_load_state;
    else if (w_hit && r_mode != M_RANDOM)
      w_state_nxt = !w_burst_end ? S_BURST : ((r_mode == M_ONESHOT) ? S_DONE : S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= M_OFF;
      r_start     <= '0;
      r_period    <= '0;
      r_burst_len <= '0;
      r_mask      <= '0;
      r_cont      <= 1'b0;
      r_first     <= 1'b0;
      r_sym_ct    <= '0;
      r_idx_sat   <= 1'b0;
      r_pcnt      <= '0;
      r_bcnt      <= '0;
      r_bad_ct    <= '0;
      r_valid     <= 1'b0;
      r_sym       <= '0;
      r_err       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_BURST);
      r_valid  <= valid_i;
      r_err    <= w_hit;
      if (valid_i) r_sym <= w_hit ? (sym_i ^ r_mask) : sym_i;

      if (cfg_load_i) begin
        r_mode      <= (mode_i == M_RANDOM && !LFSR_EN) ? M_OFF : mode_t'(mode_i);
        r_start     <= start_i;
        r_period    <= period_i;
        r_burst_len <= burst_len_i;
        r_mask      <= mask_i;
        // short periods leave no gap between bursts, so the burst simply never ends
        r_cont      <= (mode_i == M_PERIODIC) &&
                       (period_i == '0 || 32'(period_i) <= 32'(burst_len_i));
        r_first     <= 1'b1;
        r_sym_ct    <= '0;
        r_idx_sat   <= 1'b0;
        r_pcnt      <= '0;
        r_bcnt      <= '0;
        r_bad_ct    <= '0;
      end else if (valid_i) begin
        r_sym_ct <= (&r_sym_ct) ? r_sym_ct : r_sym_ct + CNT_W'(1);
        if (&r_sym_ct) r_idx_sat <= 1'b1;
        if (w_hit && r_state == S_WAIT)
          r_pcnt <= CNT_W'(1);
        else
          r_pcnt <= (&r_pcnt) ? r_pcnt : r_pcnt + CNT_W'(1);
        if (w_hit) r_bad_ct <= w_bad_sum[CNT_W] ? '1 : w_bad_sum[CNT_W-1:0];
        if (w_hit && r_mode != M_RANDOM) begin
          r_first <= 1'b0;
          r_bcnt  <= w_bcnt_nxt;
        end
      end
    end
  end

  assign valid_o      = r_valid;
  assign sym_o        = r_sym;
  assign err_o        = r_err;
  assign active_o     = r_active;
  assign sym_ct_o     = r_sym_ct;
  assign bad_bit_ct_o = r_bad_ct;
endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Self-checking bench for viterbi_channel_injector: vector table, corner sequences, randomized runs
// checked against an index-arithmetic reference model.
module tb_viterbi_channel_injector;
`ifdef VITERBI_INJ_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_load_i, valid_i;
  logic [1:0]  mode_i, mask_i, sym_i;
  logic [15:0] start_i, period_i, thresh_i;
  logic [7:0]  burst_len_i;
  logic        valid_o, err_o, active_o;
  logic [1:0]  sym_o;
  logic [15:0] sym_ct_o, bad_bit_ct_o;
  logic        valid4, err4, active4;
  logic [1:0]  sym4;
  logic [3:0]  sym_ct4, bad4;

  always #5 clk = ~clk;

  viterbi_channel_injector dut (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load_i), .mode_i(mode_i), .start_i(start_i),
    .period_i(period_i), .burst_len_i(burst_len_i), .mask_i(mask_i), .thresh_i(thresh_i),
    .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
    .active_o(active_o), .sym_ct_o(sym_ct_o), .bad_bit_ct_o(bad_bit_ct_o)
  );

  viterbi_channel_injector #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load_i), .mode_i(mode_i), .start_i(start_i[3:0]),
    .period_i(period_i[3:0]), .burst_len_i(burst_len_i), .mask_i(mask_i), .thresh_i(thresh_i),
    .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid4), .sym_o(sym4), .err_o(err4),
    .active_o(active4), .sym_ct_o(sym_ct4), .bad_bit_ct_o(bad4)
  );

  int n_pass = 0, n_total = 0;
  int m_mode, m_start, m_period, m_len, m_mask, m_thresh, m_k, m_bad, m_hits;
  logic [1:0]  m_sym;
  logic [15:0] m_lfsr;
  int n_err_seen, n_err4;

  typedef struct {
    int mode, start, period, len, mask, nsym, exp_errs, exp_bad, exp_active;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  // Whether the k-th valid symbol since the last load is corrupted, from the mode rules alone.
  function automatic bit model_hit(input int k);
    case (m_mode)
      1: return (k >= m_start) && (k < m_start + m_len);
      2: begin
        if (m_len == 0 || k < m_start) return 1'b0;
        if (m_period == 0 || m_period <= m_len) return 1'b1;
        return ((k - m_start) % m_period) < m_len;
      end
      3: return (k >= m_start) && (int'(m_lfsr) < m_thresh);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outs(input string tag, input bit v, input bit hit);
    chk({tag, "_valid_o"}, valid_o, v);
    chk({tag, "_err_o"}, err_o, hit);
    chk({tag, "_sym_o"}, sym_o, m_sym);
    chk({tag, "_sym_ct_o"}, sym_ct_o, m_k);
    chk({tag, "_bad_bit_ct_o"}, bad_bit_ct_o, m_bad);
  endtask

  task automatic run(input bit v, input logic [1:0] s);
    bit hit;
    rst = 1'b0; cfg_load_i = 1'b0; valid_i = v; sym_i = s;
    hit = v && model_hit(m_k);
    @(posedge clk); #1;
    if (v) begin
      m_sym = hit ? (s ^ 2'(m_mask)) : s;
      if (hit) begin
        m_hits++;
        m_bad = m_bad + $countones(2'(m_mask));
        if (m_bad > 65535) m_bad = 65535;
      end
      if (m_k < 65535) m_k++;
      m_lfsr = lfsr_step(m_lfsr);
    end
    check_outs("run", v, hit);
    if (err_o) n_err_seen++;
    if (err4) n_err4++;
    valid_i = 1'b0;
  endtask

  task automatic load(input int mode, input int start, input int period, input int len,
                      input int mask, input int thresh, input bit v, input logic [1:0] s);
    rst = 1'b0; cfg_load_i = 1'b1; valid_i = v; sym_i = s;
    mode_i = 2'(mode); start_i = 16'(start); period_i = 16'(period);
    burst_len_i = 8'(len); mask_i = 2'(mask); thresh_i = 16'(thresh);
    @(posedge clk); #1;
    cfg_load_i = 1'b0; valid_i = 1'b0;
    m_mode = (mode == 3 && !LFSR_EN) ? 0 : mode;
    m_start = start; m_period = period; m_len = len; m_mask = mask; m_thresh = thresh;
    m_k = 0; m_bad = 0; m_hits = 0; m_lfsr = 16'hACE1;
    if (v) m_sym = s;
    n_err_seen = 0; n_err4 = 0;
    check_outs("load", v, 1'b0);
    // config inputs must be ignored until the next load
    mode_i = 2'($urandom); start_i = 16'($urandom); period_i = 16'($urandom);
    burst_len_i = 8'($urandom); mask_i = 2'($urandom); thresh_i = 16'($urandom);
  endtask

  task automatic do_reset(input bit with_load);
    rst = 1'b1; cfg_load_i = with_load; valid_i = 1'b1; sym_i = 2'b11;
    mode_i = 2'd1; start_i = '0; period_i = '0; burst_len_i = 8'd4; mask_i = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; cfg_load_i = 1'b0; valid_i = 1'b0;
    m_mode = 0; m_k = 0; m_bad = 0; m_hits = 0; m_sym = 2'b00; m_lfsr = 16'hACE1;
    n_err_seen = 0; n_err4 = 0;
    check_outs("reset", 1'b0, 1'b0);
    chk("reset_active_o", active_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_load_i = 1'b0; valid_i = 1'b0; sym_i = '0;
    mode_i = '0; start_i = '0; period_i = '0; burst_len_i = '0; mask_i = '0; thresh_i = '0;

    //          mode start per len mask nsym errs bad active
    tbl[0] = '{1, 245,  0, 11, 1, 300, 11, 11, 0};
    tbl[1] = '{2,   4, 10,  2, 3,  30,  6, 12, 1};
    tbl[2] = '{2,   2,  3,  3, 1,  10,  8,  8, 1};
    tbl[3] = '{2,   5,  0,  1, 2,  12,  7,  7, 1};
    tbl[4] = '{1,   0,  0,  0, 3,   8,  0,  0, 0};
    tbl[5] = '{0,   0,  0,  4, 3,  10,  0,  0, 0};
    tbl[6] = '{1,   0,  0,  3, 0,   5,  3,  0, 0};
    tbl[7] = '{2,   0,  4,  1, 1,   9,  3,  3, 1};

    do_reset(1'b1);

    foreach (tbl[i]) begin
      load(tbl[i].mode, tbl[i].start, tbl[i].period, tbl[i].len, tbl[i].mask, 0, 1'b0, 2'b00);
      repeat (tbl[i].nsym) run(1'b1, 2'b10);
      chk($sformatf("tbl%0d_errs", i), n_err_seen, tbl[i].exp_errs);
      chk($sformatf("tbl%0d_bad", i), bad_bit_ct_o, tbl[i].exp_bad);
      chk($sformatf("tbl%0d_sym_ct", i), sym_ct_o, tbl[i].nsym);
      chk($sformatf("tbl%0d_active", i), active_o, tbl[i].exp_active);
    end

    // valid_i toggling: only the 4th and 5th valid symbols corrupted
    load(1, 3, 0, 2, 1, 0, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) run((i % 2) == 0, 2'($urandom));
    chk("toggle_errs", n_err_seen, 2);

    // load during a burst aborts it; the load-cycle symbol passes clean
    load(1, 0, 0, 5, 3, 0, 1'b0, 2'b00);
    run(1'b1, 2'b01);
    run(1'b1, 2'b10);
    load(0, 0, 0, 0, 0, 0, 1'b1, 2'b11);
    chk("abort_active", active_o, 1'b0);
    repeat (4) run(1'b1, 2'($urandom));
    chk("abort_errs", n_err_seen, 0);

    // reset on the 2nd symbol of a 5-symbol burst
    load(1, 0, 0, 5, 3, 0, 1'b0, 2'b00);
    run(1'b1, 2'b01);
    do_reset(1'b0);
    repeat (5) run(1'b1, 2'($urandom));
    chk("postrst_errs", n_err_seen, 0);
    chk("postrst_active", active_o, 1'b0);

    // 4-bit counters saturate
    do_reset(1'b0);
    load(0, 0, 0, 0, 0, 0, 1'b0, 2'b00);
    repeat (20) begin
      run(1'b1, 2'($urandom));
      chk("cnt4_valid", valid4, 1'b1);
      chk("cnt4_sym", sym4, m_sym);
    end
    chk("cnt4_sym_ct", sym_ct4, 4'd15);
    chk("cnt4_bad", bad4, 4'd0);
    chk("cnt4_errs", n_err4, 0);
    chk("cnt4_active", active4, 1'b0);

    // random mode
    load(3, 10, 0, 0, 3, 0, 1'b0, 2'b00);
    chk("rnd0_active", active_o, LFSR_EN);
    repeat (1000) run(1'b1, 2'($urandom));
    chk("rnd0_errs", n_err_seen, 0);
    load(3, 0, 0, 0, 3, 16'h8000, 1'b0, 2'b00);
    repeat (1000) run(1'b1, 2'($urandom));
    chk("rnd8000_errs", n_err_seen, m_hits);
    chk("rnd8000_active", active_o, LFSR_EN);
    if (!LFSR_EN) chk("rnd8000_none", n_err_seen, 0);

    // randomized configurations and traffic
    for (int r = 0; r < 25; r++) begin
      load($urandom_range(0, 3), $urandom_range(0, 30), $urandom_range(0, 12),
           $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 65535),
           1'($urandom_range(0, 1)), 2'($urandom));
      repeat (80) run($urandom_range(0, 3) != 0, 2'($urandom));
      chk("rand_hits", n_err_seen, m_hits);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
